// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
// Imported by the channel and the top-level wrapper.
package clk_div_pkg;

    localparam int DW_DEFAULT       = 16;
    localparam int DEF_DIV_DEFAULT  = 100;
    localparam int DEF_HIGH_DEFAULT = 50;

    // Channel index width; a single channel still needs one select bit.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow pair, pending flag
// and registered clk_out/tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int DEF_DIV  = DEF_DIV_DEFAULT,
    parameter int DEF_HIGH = DEF_HIGH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_ld,
    input  logic [DW-1:0] i_div,
    input  logic [DW-1:0] i_high,
    output logic          o_pend,
    output logic          o_clk,
    output logic          o_tick
);

    logic [DW-1:0] r_div;
    logic [DW-1:0] r_high;
    logic [DW-1:0] r_sdiv;
    logic [DW-1:0] r_shigh;
    logic [DW-1:0] r_cnt;
    logic          r_pend;
    logic          r_clk;
    logic          r_tick;

    logic          w_run;
    logic          w_last;
    logic          w_wrap;
    logic          w_swap;

    // div==0 parks the channel; div<=1 makes every cycle a wrap.
    assign w_run  = i_en && (r_div != '0);
    assign w_last = (r_cnt == r_div - DW'(1));
    assign w_wrap = (r_div <= DW'(1)) || w_last;
    assign w_swap = r_pend && (!i_en || w_wrap);

    // Output registers sample the pre-update counter and active pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_clk  <= w_run && (r_cnt < r_high);
            r_tick <= w_run && w_last;
        end
    end

    // Counter: cleared when stopped/disabled, restarts on every wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!w_run || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

    // Active/shadow pairs; a load is only accepted while not pending,
    // so capture and swap never collide on the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= DW'(DEF_DIV);
            r_high  <= DW'(DEF_HIGH);
            r_sdiv  <= DW'(DEF_DIV);
            r_shigh <= DW'(DEF_HIGH);
            r_pend  <= 1'b0;
        end else if (w_swap) begin
            r_div  <= r_sdiv;
            r_high <= r_shigh;
            r_pend <= 1'b0;
        end else if (i_ld) begin
            r_sdiv  <= i_div;
            r_shigh <= i_high;
            r_pend  <= 1'b1;
        end
    end

    assign o_pend = r_pend;
    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with a shared
// valid/ready load port; each channel runs independently.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int DW       = DW_DEFAULT,
    parameter int DEF_DIV  = DEF_DIV_DEFAULT,
    parameter int DEF_HIGH = DEF_HIGH_DEFAULT,
    localparam int CW      = ch_idx_w(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] en,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [CW-1:0]  load_ch,
    input  logic [DW-1:0]  load_div,
    input  logic [DW-1:0]  load_high,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    logic [NCH-1:0] w_pend;
    logic [NCH-1:0] w_ld;

    // Ready follows the addressed channel's pending flag; an index
    // with no channel matches nothing and is accepted and dropped.
    always_comb begin
        load_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (load_ch == CW'(i)) begin
                load_ready = !w_pend[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign w_ld[g] = load_valid && load_ready &&
                         (load_ch == CW'(g));

        clk_div_chan #(
            .DW       (DW),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .i_en   (en[g]),
            .i_ld   (w_ld[g]),
            .i_div  (load_div),
            .i_high (load_high),
            .o_pend (w_pend[g]),
            .o_clk  (clk_out[g]),
            .o_tick (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic,
// checked against a phase-from-start-time reference model.
module tb_clk_div_prog;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int CW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [CW-1:0]  load_ch = '0;
    logic [DW-1:0]  load_div = '0;
    logic [DW-1:0]  load_high = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    always #5 clk = ~clk;

    clk_div_prog #(.NCH(NCH)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_ch    (load_ch),
        .load_div   (load_div),
        .load_high  (load_high),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: active/shadow pairs, pending, and the edge index at
    // which the current period started; phase = (t - start) % div.
    int m_div[NCH];
    int m_high[NCH];
    int m_sdiv[NCH];
    int m_shigh[NCH];
    int m_start[NCH];
    bit m_pend[NCH];
    int t = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_div[c]   = 100;
            m_high[c]  = 50;
            m_sdiv[c]  = 100;
            m_shigh[c] = 50;
            m_pend[c]  = 1'b0;
            m_start[c] = t;
        end
    endtask

    task automatic step();
        logic [NCH-1:0] ec;
        logic [NCH-1:0] et;
        bit rdy;
        bit acc;
        int ph;
        #1;
        rdy = (int'(load_ch) < NCH) ? !m_pend[load_ch] : 1'b1;
        chk("load_ready", {31'd0, load_ready}, {31'd0, rdy});
        acc = load_valid && rdy;
        for (int c = 0; c < NCH; c++) begin
            ph = (m_div[c] == 0) ? 0 : (t - m_start[c]) % m_div[c];
            ec[c] = en[c] && m_div[c] != 0 && ph < m_high[c];
            et[c] = en[c] && m_div[c] != 0 && ph == m_div[c] - 1;
            if (!en[c] || m_div[c] == 0) m_start[c] = t + 1;
            if (m_pend[c] && (!en[c] || m_div[c] <= 1 ||
                              ph == m_div[c] - 1)) begin
                m_div[c]   = m_sdiv[c];
                m_high[c]  = m_shigh[c];
                m_pend[c]  = 1'b0;
                m_start[c] = t + 1;
            end
            if (acc && int'(load_ch) == c) begin
                m_sdiv[c]  = int'(load_div);
                m_shigh[c] = int'(load_high);
                m_pend[c]  = 1'b1;
            end
        end
        @(posedge clk);
        t++;
        #1;
        chk("clk_out", {29'd0, clk_out}, {29'd0, ec});
        chk("tick", {29'd0, tick}, {29'd0, et});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_out", {29'd0, clk_out}, 32'd0);
        chk("rst_tick", {29'd0, tick}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic load(input int ch, input int d, input int h);
        load_valid = 1'b1;
        load_ch    = CW'(ch);
        load_div   = DW'(d);
        load_high  = DW'(h);
        step();
        load_valid = 1'b0;
    endtask

    int first;
    int highs;

    initial begin
        do_reset();

        // Defaults on ch0: first tick and high time of first period.
        en = 3'b001;
        first = -1;
        highs = 0;
        for (int i = 1; i <= 250; i++) begin
            step();
            if (first < 0 && tick[0]) first = i;
            if (i <= 100 && clk_out[0]) highs++;
        end
        chk("first_tick", first, 100);
        chk("high_cycles", highs, 50);

        // Mid-period reprogram of ch0, then ch1 stopped with div=0.
        load(0, 10, 3);
        repeat (200) step();
        en = 3'b011;
        repeat (30) step();
        load(1, 0, 5);
        repeat (250) step();

        // ch2: div=1 then high>=div.
        load(2, 1, 1);
        step();
        en[2] = 1'b1;
        repeat (20) step();
        load(2, 5, 7);
        repeat (30) step();

        // Disable at cnt=37, reload while off, re-enable.
        do_reset();
        en = 3'b001;
        repeat (37) step();
        en[0] = 1'b0;
        step();
        load(0, 4, 2);
        step();
        en[0] = 1'b1;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (first < 0 && tick[0]) first = i;
        end
        chk("reen_tick", first, 4);

        // Asynchronous reset with a load still pending on ch1.
        do_reset();
        en = 3'b011;
        repeat (10) step();
        load(1, 6, 2);
        load_ch = 2'd1;
        repeat (5) step();
        rst = 1'b0;
        #1;
        chk("async_clk_out", {29'd0, clk_out}, 32'd0);
        chk("async_tick", {29'd0, tick}, 32'd0);
        chk("async_ready", {31'd0, load_ready}, 32'd1);
        do_reset();
        repeat (150) step();

        // Random traffic, including the out-of-range index 3.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            load_valid = ($urandom_range(0, 5) == 0);
            load_ch    = CW'($urandom_range(0, 3));
            load_div   = DW'($urandom_range(0, 12));
            load_high  = DW'($urandom_range(0, 14));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
